// File: rtl/selen_mem_arb_pkg.sv
// selen_mem_arb_pkg: shared types and constants for the Selen memory arbiter.
//   state_e - arbiter FSM states (IDLE, BUS)
//   port_e  - requester identity (PORT_I instruction, PORT_D data)
//   ARB_TIMEOUT_DATA - read data returned on a forced watchdog response
package selen_mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_e;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/selen_mem_arb_wdog.sv
// selen_mem_arb_wdog: bus-cycle watchdog counter.
//   clk, rst   - clock, synchronous active-high reset
//   start_i    - grant issued this edge; count loads to 1 (first BUS cycle)
//   clear_i    - transfer finished; count returns to 0
//   busy_i     - arbiter is in BUS this cycle
//   expire_o   - high in the BUS cycle where the count has reached TIMEOUT
module selen_mem_arb_wdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic clear_i,
    input  logic busy_i,
    output logic expire_o
);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i)
            cnt_d = '0;
        else if (start_i)
            cnt_d = CW'(1);
        else if (busy_i && cnt_q != CW'(TIMEOUT))
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign expire_o = busy_i && (cnt_q == CW'(TIMEOUT));

endmodule

// File: rtl/selen_mem_arb.sv
// selen_mem_arb: two-port (instruction/data) arbiter onto one Wishbone master.
//   i_req_*  - instruction read request; i_req_ack/i_ack_rdata/i_ack_err response
//   d_req_*  - data read/write request; d_req_ack/d_ack_rdata/d_ack_err response
//   wb_*_o   - registered Wishbone master outputs; wb_ack_i/wb_err_i/wb_dat_i slave reply
// Data port has priority; after D_BURST_MAX data grants with an instruction
// request pending, the instruction port wins the next arbitration.
// Optional macro SELEN_MEM_ARB_TIMEOUT_EN adds a BUS watchdog that forces an
// error response (rdata ARB_TIMEOUT_DATA) after TIMEOUT cycles without reply.
import selen_mem_arb_pkg::*;

module selen_mem_arb #(
    parameter int unsigned AW          = 32,
    parameter int unsigned DW          = 32,
    parameter int unsigned D_BURST_MAX = 4,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req_val,
    input  logic [AW-1:0]   i_req_addr,
    output logic            i_req_ack,
    output logic [DW-1:0]   i_ack_rdata,
    output logic            i_ack_err,
    input  logic            d_req_val,
    input  logic            d_req_we,
    input  logic [AW-1:0]   d_req_addr,
    input  logic [DW-1:0]   d_req_wdata,
    input  logic [DW/8-1:0] d_req_be,
    output logic            d_req_ack,
    output logic [DW-1:0]   d_ack_rdata,
    output logic            d_ack_err,
    output logic            wb_cyc_o,
    output logic            wb_stb_o,
    output logic            wb_we_o,
    output logic [AW-1:0]   wb_adr_o,
    output logic [DW-1:0]   wb_dat_o,
    output logic [DW/8-1:0] wb_sel_o,
    input  logic            wb_ack_i,
    input  logic            wb_err_i,
    input  logic [DW-1:0]   wb_dat_i
);
    localparam int unsigned SCW = $clog2(D_BURST_MAX + 1);

    state_e          state_q;
    port_e           gnt_q;
    logic [SCW-1:0]  starve_q;

    logic            in_bus, bus_rsp, expire, done, fire, grant, pick_d;
    logic            rsp_err;
    logic [DW-1:0]   rsp_data;

    assign in_bus  = (state_q == BUS);
    assign bus_rsp = wb_ack_i | wb_err_i;
    assign grant   = (state_q == IDLE) && (i_req_val || d_req_val);
    assign pick_d  = d_req_val && !(i_req_val && starve_q == SCW'(D_BURST_MAX));

`ifdef SELEN_MEM_ARB_TIMEOUT_EN
    selen_mem_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .start_i  (grant),
        .clear_i  (fire),
        .busy_i   (in_bus),
        .expire_o (expire)
    );
    // A real slave reply in the expiry cycle wins over the forced error.
    assign rsp_err  = bus_rsp ? wb_err_i : 1'b1;
    assign rsp_data = bus_rsp ? wb_dat_i : ARB_TIMEOUT_DATA;
`else
    assign expire   = 1'b0;
    assign rsp_err  = wb_err_i;
    assign rsp_data = wb_dat_i;
`endif

    assign done = bus_rsp | expire;
    assign fire = in_bus & done;

    assign i_req_ack   = fire && (gnt_q == PORT_I);
    assign d_req_ack   = fire && (gnt_q == PORT_D);
    assign i_ack_err   = i_req_ack & rsp_err;
    assign d_ack_err   = d_req_ack & rsp_err;
    assign i_ack_rdata = rsp_data;
    assign d_ack_rdata = rsp_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt_q    <= PORT_I;
            starve_q <= '0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
        end else begin
            case (state_q)
                IDLE: if (grant) begin
                    state_q  <= BUS;
                    wb_cyc_o <= 1'b1;
                    wb_stb_o <= 1'b1;
                    if (pick_d) begin
                        gnt_q    <= PORT_D;
                        wb_we_o  <= d_req_we;
                        wb_adr_o <= d_req_addr;
                        wb_dat_o <= d_req_wdata;
                        wb_sel_o <= d_req_be;
                        // Count only data grants that overtook a waiting fetch.
                        if (!i_req_val)
                            starve_q <= '0;
                        else if (starve_q != SCW'(D_BURST_MAX))
                            starve_q <= starve_q + SCW'(1);
                    end else begin
                        gnt_q    <= PORT_I;
                        wb_we_o  <= 1'b0;
                        wb_adr_o <= i_req_addr;
                        wb_dat_o <= '0;
                        wb_sel_o <= '1;
                        starve_q <= '0;
                    end
                end
                BUS: if (done) begin
                    state_q  <= IDLE;
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_selen_mem_arb.sv
module tb_selen_mem_arb;
    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_val;
    logic [31:0] i_req_addr;
    logic        i_req_ack;
    logic [31:0] i_ack_rdata;
    logic        i_ack_err;
    logic        d_req_val, d_req_we;
    logic [31:0] d_req_addr, d_req_wdata;
    logic [3:0]  d_req_be;
    logic        d_req_ack;
    logic [31:0] d_ack_rdata;
    logic        d_ack_err;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_ack_i, wb_err_i;
    logic [31:0] wb_dat_i;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    selen_mem_arb #(.AW(32), .DW(32), .D_BURST_MAX(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_req_val(i_req_val), .i_req_addr(i_req_addr), .i_req_ack(i_req_ack),
        .i_ack_rdata(i_ack_rdata), .i_ack_err(i_ack_err),
        .d_req_val(d_req_val), .d_req_we(d_req_we), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_be(d_req_be), .d_req_ack(d_req_ack),
        .d_ack_rdata(d_ack_rdata), .d_ack_err(d_ack_err),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_dat_i(wb_dat_i)
    );

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_req_val = 0; i_req_addr = '0;
        d_req_val = 0; d_req_we = 0; d_req_addr = '0; d_req_wdata = '0; d_req_be = '0;
        wb_ack_i = 0; wb_err_i = 0; wb_dat_i = '0;
        step(); step();
        tests++; if ({wb_cyc_o, wb_stb_o, wb_we_o} !== 3'b000) begin fails++;
            $display("FAIL reset_ctl got %b want 000", {wb_cyc_o, wb_stb_o, wb_we_o}); end
        tests++; if ({wb_adr_o, wb_dat_o, wb_sel_o} !== 68'h0) begin fails++;
            $display("FAIL reset_bus got %h/%h/%h want 0", wb_adr_o, wb_dat_o, wb_sel_o); end
        rst = 1'b0;
        // Slave reply while IDLE must be ignored.
        wb_ack_i = 1; wb_err_i = 1; #1;
        tests++; if ({i_req_ack, d_req_ack, i_ack_err, d_ack_err} !== 4'b0000) begin fails++;
            $display("FAIL idle_rsp got %b want 0000", {i_req_ack, d_req_ack, i_ack_err, d_ack_err}); end
        step();
        tests++; if (wb_cyc_o !== 1'b0) begin fails++;
            $display("FAIL idle_cyc got %b want 0", wb_cyc_o); end
        wb_ack_i = 0; wb_err_i = 0;
    endtask

    task automatic test_single_i();
        i_req_val = 1; i_req_addr = 32'h0000_0100; wb_dat_i = 32'h0000_0013;
        step();
        tests++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b110_1111) begin fails++;
            $display("FAIL i_bus_ctl got %b want 1101111", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
        tests++; if (wb_adr_o !== 32'h100) begin fails++;
            $display("FAIL i_adr got %h want 00000100", wb_adr_o); end
        wb_ack_i = 1; #1;
        tests++; if ({i_req_ack, i_ack_err, d_req_ack} !== 3'b100) begin fails++;
            $display("FAIL i_ack got %b want 100", {i_req_ack, i_ack_err, d_req_ack}); end
        tests++; if (i_ack_rdata !== 32'h13) begin fails++;
            $display("FAIL i_rdata got %h want 00000013", i_ack_rdata); end
        step();
        i_req_val = 0; wb_ack_i = 0; #1;
        tests++; if ({wb_cyc_o, i_req_ack} !== 2'b00) begin fails++;
            $display("FAIL i_end got %b want 00", {wb_cyc_o, i_req_ack}); end
    endtask

    task automatic test_d_write();
        d_req_val = 1; d_req_we = 1; d_req_addr = 32'h0001_0004;
        d_req_wdata = 32'hA5A5_5A5A; d_req_be = 4'b0011;
        step();
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) begin wb_ack_i = 1; #1; end
            tests++; if ({wb_cyc_o, wb_we_o, wb_sel_o} !== 6'b11_0011) begin fails++;
                $display("FAIL d_ctl c%0d got %b want 110011", c, {wb_cyc_o, wb_we_o, wb_sel_o}); end
            tests++; if ({d_req_ack, d_ack_err, i_req_ack} !== ((c == 3) ? 3'b100 : 3'b000)) begin fails++;
                $display("FAIL d_ack c%0d got %b want %b", c, {d_req_ack, d_ack_err, i_req_ack},
                         (c == 3) ? 3'b100 : 3'b000); end
            if (c < 3) step();
        end
        tests++; if ({wb_adr_o, wb_dat_o} !== {32'h0001_0004, 32'hA5A5_5A5A}) begin fails++;
            $display("FAIL d_adr_dat got %h/%h want 00010004/a5a55a5a", wb_adr_o, wb_dat_o); end
        step();
        d_req_val = 0; d_req_we = 0; wb_ack_i = 0; #1;
        tests++; if (wb_cyc_o !== 1'b0) begin fails++;
            $display("FAIL d_end got %b want 0", wb_cyc_o); end
    endtask

    task automatic test_contention();
        logic exp_d;
        i_req_val = 1; i_req_addr = 32'h0000_0400;
        d_req_val = 1; d_req_we = 0; d_req_addr = 32'h0000_8000; d_req_be = 4'hF;
        wb_ack_i = 1;
        for (int k = 0; k < 10; k++) begin
            exp_d = (k % 5) != 4;
            step();
            tests++; if ({d_req_ack, i_req_ack} !== {exp_d, ~exp_d}) begin fails++;
                $display("FAIL contend_%0d got d%b i%b want d%b i%b", k, d_req_ack, i_req_ack, exp_d, ~exp_d); end
            tests++; if (wb_adr_o !== (exp_d ? 32'h8000 : 32'h400)) begin fails++;
                $display("FAIL contend_adr_%0d got %h want %h", k, wb_adr_o, exp_d ? 32'h8000 : 32'h400); end
            step();
        end
        i_req_val = 0; d_req_val = 0; wb_ack_i = 0;
    endtask

    task automatic test_slave_err();
        d_req_val = 1; d_req_we = 0; d_req_addr = 32'h0000_2000; d_req_be = 4'hF;
        step();
        wb_err_i = 1; wb_dat_i = 32'h0000_1234; #1;
        tests++; if ({d_req_ack, d_ack_err, i_req_ack} !== 3'b110) begin fails++;
            $display("FAIL err_ack got %b want 110", {d_req_ack, d_ack_err, i_req_ack}); end
        step();
        tests++; if (wb_cyc_o !== 1'b0) begin fails++;
            $display("FAIL err_idle got %b want 0", wb_cyc_o); end
        // Held request re-grants; ack and err together count as an error.
        step();
        wb_ack_i = 1; #1;
        tests++; if ({d_req_ack, d_ack_err} !== 2'b11) begin fails++;
            $display("FAIL ackerr got %b want 11", {d_req_ack, d_ack_err}); end
        step();
        d_req_val = 0; wb_ack_i = 0; wb_err_i = 0;
    endtask

    task automatic test_reset_mid();
        i_req_val = 1; i_req_addr = 32'h0000_0200; wb_dat_i = 32'h0000_0055;
        step();
        tests++; if (wb_cyc_o !== 1'b1) begin fails++;
            $display("FAIL rstmid_bus got %b want 1", wb_cyc_o); end
        rst = 1;
        step();
        tests++; if ({wb_cyc_o, wb_stb_o, i_req_ack} !== 3'b000) begin fails++;
            $display("FAIL rstmid_abort got %b want 000", {wb_cyc_o, wb_stb_o, i_req_ack}); end
        rst = 0;
        step();
        tests++; if ({wb_cyc_o, wb_adr_o} !== {1'b1, 32'h200}) begin fails++;
            $display("FAIL rstmid_reissue got %b/%h want 1/00000200", wb_cyc_o, wb_adr_o); end
        wb_ack_i = 1; #1;
        tests++; if ({i_req_ack, i_ack_err, i_ack_rdata} !== {2'b10, 32'h55}) begin fails++;
            $display("FAIL rstmid_ack got %b%b/%h want 10/00000055", i_req_ack, i_ack_err, i_ack_rdata); end
        step();
        i_req_val = 0; wb_ack_i = 0;
    endtask

`ifdef SELEN_MEM_ARB_TIMEOUT_EN
    task automatic test_watchdog();
        i_req_val = 1; i_req_addr = 32'h0000_0300; wb_dat_i = 32'h0;
        step();
        for (int c = 1; c < 8; c++) begin
            tests++; if (i_req_ack !== 1'b0) begin fails++;
                $display("FAIL wdog_early c%0d got %b want 0", c, i_req_ack); end
            step();
        end
        tests++; if ({i_req_ack, i_ack_err, i_ack_rdata} !== {2'b11, 32'hDEAD_BEEF}) begin fails++;
            $display("FAIL wdog_fire got %b%b/%h want 11/deadbeef", i_req_ack, i_ack_err, i_ack_rdata); end
        step();
        i_req_val = 0; #1;
        tests++; if (wb_cyc_o !== 1'b0) begin fails++;
            $display("FAIL wdog_end got %b want 0", wb_cyc_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_i();
        test_d_write();
        test_contention();
        test_slave_err();
        test_reset_mid();
`ifdef SELEN_MEM_ARB_TIMEOUT_EN
        test_watchdog();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/selen_mem_arb.md
# selen_mem_arb

Two-requester memory arbiter between the Selen core's instruction port (`i_req_*`) and data port (`d_req_*`) and the single Wishbone master bus. The Wishbone bus reaches the ROM, the RAM and the peripheral (GPIO/SPI) slaves. The arbiter grants one port at a time and holds the grant for a whole bus cycle. It prefers the data port, with a bounded anti-starvation rule for instruction fetch, and returns the slave response on the granted port's ack.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width; `DW/8` byte lanes.
- `D_BURST_MAX`, 4, maximum consecutive data grants while an instruction request is pending.
- `TIMEOUT`, 255, bus-watchdog limit in cycles; used only with the macro.

Clocking and reset (already decided): one clock `clk`; reset `rst`, synchronous, active-high.

- `clk` in 1 system clock
- `rst` in 1 synchronous active-high reset
- `i_req_val` in 1 instruction read request
- `i_req_addr` in AW instruction address
- `i_req_ack` out 1 one-cycle response strobe
- `i_ack_rdata` out DW read data, valid with `i_req_ack`
- `i_ack_err` out 1 bus error, valid with `i_req_ack`
- `d_req_val` in 1 data request
- `d_req_we` in 1 1=write
- `d_req_addr` in AW data address
- `d_req_wdata` in DW write data
- `d_req_be` in DW/8 byte enables
- `d_req_ack`, `d_ack_rdata`, `d_ack_err` out 1/DW/1 as for the instruction port
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o` out 1 Wishbone cycle, strobe, write enable
- `wb_adr_o` out AW Wishbone address
- `wb_dat_o` out DW Wishbone write data
- `wb_sel_o` out DW/8 Wishbone byte selects
- `wb_ack_i`, `wb_err_i` in 1 slave acknowledge / error
- `wb_dat_i` in DW slave read data

## Operation
- Requesters hold `*_req_val` and all request fields stable until their ack. Changing them before the ack is illegal.
- FSM states are `IDLE` and `BUS`. Reset enters `IDLE`.
- **IDLE, grant selection:**
  - If only one `val` is high, that port wins.
  - If both are high, D wins unless `starve_cnt == D_BURST_MAX`, in which case I wins.
  - The selected request is registered onto `wb_*_o` and the FSM goes to `BUS`.
- **IDLE, instruction port fields:** the instruction port always drives `wb_we_o=0` and `wb_sel_o` all ones.
- **starve_cnt:**
  - Increments on each D grant while `i_req_val` is high.
  - Clears on an I grant, or when `i_req_val` is low at grant time.
  - Saturates at `D_BURST_MAX`.
- **BUS:** `wb_cyc_o` and `wb_stb_o` stay high until `wb_ack_i | wb_err_i`. In that cycle:
  - The granted port's `*_req_ack` is high combinationally.
  - `*_ack_rdata = wb_dat_i`.
  - `*_ack_err = wb_err_i`.
  - On the next edge `cyc`/`stb` drop and the FSM returns to `IDLE`.
- `wb_ack_i` and `wb_err_i` both high: treat as error.
- Slave responses while in `IDLE` are ignored.
- The ungranted port's ack is never asserted. Both rdata outputs may mirror `wb_dat_i`; they are qualified only by ack.
- Reset mid-`BUS`: the cycle is abandoned, with no ack to the requester. The requester re-issues after reset.

## Timing
- Reset values:
  - `wb_cyc_o`, `wb_stb_o`, `wb_we_o`: 0.
  - `wb_adr_o`, `wb_dat_o`, `wb_sel_o`: 0.
  - All acks and errs: 0.
  - `starve_cnt`: 0.
- The `rst` effect is visible after the first rising edge at which it is sampled high.
- A `val` sampled high at edge N produces `cyc`/`stb` high from edge N+1.
- Minimum latency, with a zero-wait slave: ack in cycle N+1.
- Throughput is one transfer per 2 cycles. Edge N+2 is spent in `IDLE` re-arbitrating.
- Wait states extend `BUS` indefinitely, subject to the watchdog when configured.

## Configuration
- `SELEN_MEM_ARB_TIMEOUT_EN` defined: a watchdog counts `BUS` cycles and clears on entering `BUS`. When the count reaches `TIMEOUT` with no slave response:
  - The arbiter forces a response: the granted port's ack=1 and err=1, rdata=`32'hDEAD_BEEF`.
  - `cyc`/`stb` drop on the next edge and the FSM returns to `IDLE`.
  - A slave response in the same cycle as expiry takes precedence over the timeout.
- Macro undefined: no watchdog logic; `BUS` waits forever; err comes only from `wb_err_i`.

## Structure
- Package `selen_mem_arb_pkg` holds:
  - the state enum (`IDLE`, `BUS`);
  - the port-id enum (`PORT_I`, `PORT_D`);
  - the constant `ARB_TIMEOUT_DATA = 32'hDEAD_BEEF`.
- Sub-module `selen_mem_arb_wdog` is the loadable timeout counter. It takes start/clear inputs and drives an expire output, and is instantiated only under the macro.

## Test plan
- **Single I read:** I read at 0x0000_0100, zero-wait slave returning 0x0000_0013 → `wb_adr_o=0x100`, `wb_we_o=0`, `wb_sel_o=4'hF` → `i_req_ack` one cycle after `val`, rdata 0x13, `d_req_ack` stays 0.
- **D write:** addr 0x0001_0004, data 0xA5A5_5A5A, be 4'b0011, slave 2 wait states → `wb_sel_o=0011` held 3 cycles, `d_req_ack` in the 3rd, `d_ack_err=0`.
- **Contention:** I and D held continuously → grant order D,D,D,D,I,D,D,D,D,I, with `D_BURST_MAX=4`.
- **Slave error:** `wb_err_i=1` on a D read → `d_req_ack=1`, `d_ack_err=1`, FSM returns to `IDLE`.
- **Reset mid-cycle:** `rst` high while in `BUS` for an I read → `wb_cyc_o=0` after the next edge, no `i_req_ack`. After reset release the re-issued read completes normally.
- **Watchdog** (`SELEN_MEM_ARB_TIMEOUT_EN`, `TIMEOUT=8`): slave never acks → ack with err=1 and rdata 0xDEAD_BEEF after 8 `BUS` cycles, `cyc` low on the following cycle.
